// File: rtl/dtree_pkg.sv
// Shared types and node-word layout for the decision-tree evaluation scheduler.
// Node word, MSB first: {leaf, feat_idx, thresh, next_t, next_f, y}.
package dtree_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NODE_AW = 8;
  localparam int DEF_FEAT_AW = 2;

  typedef enum logic [1:0] {IDLE, FETCH, EVAL, RESP} state_t;

  function automatic int node_w(input int feat_aw, input int data_w, input int node_aw);
    return 1 + feat_aw + 2 * data_w + 2 * node_aw;
  endfunction

  // Field LSB offsets within a node word; y sits at bit 0 and leaf is the MSB.
  function automatic int off_next_f(input int data_w);
    return data_w;
  endfunction

  function automatic int off_next_t(input int data_w, input int node_aw);
    return data_w + node_aw;
  endfunction

  function automatic int off_thresh(input int data_w, input int node_aw);
    return data_w + 2 * node_aw;
  endfunction

  function automatic int off_feat_idx(input int data_w, input int node_aw);
    return 2 * data_w + 2 * node_aw;
  endfunction

  typedef struct packed {
    logic                   leaf;
    logic [DEF_FEAT_AW-1:0] feat_idx;
    logic [DEF_DATA_W-1:0]  thresh;
    logic [DEF_NODE_AW-1:0] next_t;
    logic [DEF_NODE_AW-1:0] next_f;
    logic [DEF_DATA_W-1:0]  y;
  } node_t;

endpackage

// File: rtl/dtree_node_ram.sv
// Node memory: one config write port and one synchronous read port, no reset.
module dtree_node_ram
  import dtree_pkg::*;
#(
  parameter int NODE_W = node_w(DEF_FEAT_AW, DEF_DATA_W, DEF_NODE_AW),
  parameter int AW     = DEF_NODE_AW
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [NODE_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  output logic [NODE_W-1:0] o_rdata
);

  logic [NODE_W-1:0] r_mem [0:(2**AW)-1];
  logic [NODE_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dtree_eval_sched.sv
// Round-robin shared decision-tree evaluator: arbitrates requesters, walks node RAM, returns tagged leaf.
// Define DTREE_STATS_EN to add saturating result/error counters (o_stat_done, o_stat_err).
module dtree_eval_sched
  import dtree_pkg::*;
#(
  parameter  int NREQ      = 4,
  parameter  int DATA_W    = 8,
  parameter  int NODE_AW   = 8,
  parameter  int FEAT_AW   = 2,
  parameter  int MAX_DEPTH = 16,
  localparam int ID_W      = $clog2(NREQ),
  localparam int FV_W      = (2**FEAT_AW) * DATA_W,
  localparam int NODE_W    = node_w(FEAT_AW, DATA_W, NODE_AW)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ*FV_W-1:0] i_req_feat,
  output logic                 o_rsp_valid,
  input  logic                 i_rsp_ready,
  output logic [ID_W-1:0]      o_rsp_id,
  output logic [DATA_W-1:0]    o_rsp_y,
  output logic                 o_rsp_err,
  input  logic                 i_cfg_we,
  input  logic [NODE_AW-1:0]   i_cfg_addr,
  input  logic [NODE_W-1:0]    i_cfg_wdata,
  output logic                 o_cfg_ready,
  output logic                 o_busy
`ifdef DTREE_STATS_EN
  ,
  output logic [31:0]          o_stat_done,
  output logic [31:0]          o_stat_err
`endif
);

  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);
  localparam int NF_LO   = off_next_f(DATA_W);
  localparam int NT_LO   = off_next_t(DATA_W, NODE_AW);
  localparam int TH_LO   = off_thresh(DATA_W, NODE_AW);
  localparam int FI_LO   = off_feat_idx(DATA_W, NODE_AW);

  state_t              r_state;
  logic [ID_W-1:0]     r_rr;
  logic [ID_W-1:0]     r_id;
  logic [FV_W-1:0]     r_feat;
  logic [NODE_AW-1:0]  r_addr;
  logic [DEPTH_W-1:0]  r_depth;
  logic                r_valid;
  logic [DATA_W-1:0]   r_y;
  logic                r_err;
  logic                r_busy;
  logic                r_cfg_ready;

  logic [ID_W-1:0]     w_gidx;
  logic                w_found;
  logic                w_grant_en;
  int                  w_idx;
  logic [NODE_W-1:0]   w_node;
  logic                w_leaf;
  logic [FEAT_AW-1:0]  w_fidx;
  logic [DATA_W-1:0]   w_thresh;
  logic [NODE_AW-1:0]  w_nt;
  logic [NODE_AW-1:0]  w_nf;
  logic [DATA_W-1:0]   w_y;
  logic [DATA_W-1:0]   w_fval;
  logic                w_gt;
  logic [DEPTH_W-1:0]  w_depth_nxt;

  dtree_node_ram #(
    .NODE_W (NODE_W),
    .AW     (NODE_AW)
  ) u_ram (
    .clk     (clk),
    .i_we    (i_cfg_we && (r_state == IDLE)),
    .i_waddr (i_cfg_addr),
    .i_wdata (i_cfg_wdata),
    .i_re    (r_state == FETCH),
    .i_raddr (r_addr),
    .o_rdata (w_node)
  );

  // Search starts just after the last winner, so every waiting requester is served within NREQ-1 grants.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_idx   = 0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = int'(r_rr) + i;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!w_found && i_req_valid[ID_W'(w_idx)]) begin
        w_found = 1'b1;
        w_gidx  = ID_W'(w_idx);
      end
    end
  end

  assign w_grant_en  = (r_state == IDLE) && !i_cfg_we && w_found;
  assign o_req_ready = w_grant_en ? (NREQ'(1) << w_gidx) : '0;

  assign w_leaf      = w_node[NODE_W-1];
  assign w_fidx      = w_node[FI_LO +: FEAT_AW];
  assign w_thresh    = w_node[TH_LO +: DATA_W];
  assign w_nt        = w_node[NT_LO +: NODE_AW];
  assign w_nf        = w_node[NF_LO +: NODE_AW];
  assign w_y         = w_node[DATA_W-1:0];
  assign w_fval      = r_feat[int'(w_fidx)*DATA_W +: DATA_W];
  assign w_gt        = w_fval > w_thresh;
  assign w_depth_nxt = r_depth + DEPTH_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_rr        <= ID_W'(NREQ - 1);
      r_id        <= '0;
      r_feat      <= '0;
      r_addr      <= '0;
      r_depth     <= '0;
      r_valid     <= 1'b0;
      r_y         <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant_en) begin
            r_feat      <= i_req_feat[int'(w_gidx)*FV_W +: FV_W];
            r_id        <= w_gidx;
            r_rr        <= w_gidx;
            r_addr      <= '0;
            r_depth     <= '0;
            r_busy      <= 1'b1;
            r_cfg_ready <= 1'b0;
            r_state     <= FETCH;
          end
        end
        FETCH: r_state <= EVAL;
        EVAL: begin
          if (w_leaf) begin
            r_y     <= w_y;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
            r_state <= RESP;
          end else begin
            r_addr  <= w_gt ? w_nt : w_nf;
            r_depth <= w_depth_nxt;
            // Depth guard is what terminates self-loops and cycles in a badly loaded tree.
            if (w_depth_nxt == DEPTH_W'(MAX_DEPTH)) begin
              r_y     <= '0;
              r_err   <= 1'b1;
              r_valid <= 1'b1;
              r_state <= RESP;
            end else begin
              r_state <= FETCH;
            end
          end
        end
        RESP: begin
          if (i_rsp_ready) begin
            r_valid     <= 1'b0;
            r_busy      <= 1'b0;
            r_cfg_ready <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_valid;
  assign o_rsp_id    = r_id;
  assign o_rsp_y     = r_y;
  assign o_rsp_err   = r_err;
  assign o_busy      = r_busy;
  assign o_cfg_ready = r_cfg_ready;

`ifdef DTREE_STATS_EN
  logic [31:0] r_stat_done;
  logic [31:0] r_stat_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_done <= '0;
      r_stat_err  <= '0;
    end else if (r_valid && i_rsp_ready) begin
      if (r_stat_done != '1) r_stat_done <= r_stat_done + 32'd1;
      if (r_err && (r_stat_err != '1)) r_stat_err <= r_stat_err + 32'd1;
    end
  end

  assign o_stat_done = r_stat_done;
  assign o_stat_err  = r_stat_err;
`endif

endmodule

// File: tb/tb_dtree_eval_sched.sv
// Directed self-checking bench for dtree_eval_sched: leaf/decision walks, round-robin order,
// depth abort, response backpressure, reset mid-walk and config-vs-request priority.
module tb_dtree_eval_sched;
  import dtree_pkg::*;

  localparam int NREQ = 4;
  localparam int MAXD = 16;
  localparam int FV_W = 32;
  localparam int NODE_W = 35;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [NREQ-1:0]      req_valid = '0;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*FV_W-1:0] req_feat = '0;
  logic                 rsp_valid;
  logic                 rsp_ready = 1'b1;
  logic [1:0]           rsp_id;
  logic [7:0]           rsp_y;
  logic                 rsp_err;
  logic                 cfg_we = 1'b0;
  logic [7:0]           cfg_addr = '0;
  logic [NODE_W-1:0]    cfg_wdata = '0;
  logic                 cfg_ready;
  logic                 busy;
`ifdef DTREE_STATS_EN
  logic [31:0]          stat_done;
  logic [31:0]          stat_err;
`endif

  int cyc = 0;
  int vecs = 0;
  int fails = 0;

  dtree_eval_sched #(
    .NREQ(NREQ), .DATA_W(8), .NODE_AW(8), .FEAT_AW(2), .MAX_DEPTH(MAXD)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_feat  (req_feat),
    .o_rsp_valid (rsp_valid),
    .i_rsp_ready (rsp_ready),
    .o_rsp_id    (rsp_id),
    .o_rsp_y     (rsp_y),
    .o_rsp_err   (rsp_err),
    .i_cfg_we    (cfg_we),
    .i_cfg_addr  (cfg_addr),
    .i_cfg_wdata (cfg_wdata),
    .o_cfg_ready (cfg_ready),
    .o_busy      (busy)
`ifdef DTREE_STATS_EN
    ,
    .o_stat_done (stat_done),
    .o_stat_err  (stat_err)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    if (obs !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic node_t mkNode(input logic leaf, input logic [1:0] fi, input logic [7:0] th,
                                   input logic [7:0] nt, input logic [7:0] nf, input logic [7:0] y);
    node_t n;
    n.leaf = leaf; n.feat_idx = fi; n.thresh = th; n.next_t = nt; n.next_f = nf; n.y = y;
    return n;
  endfunction

  task automatic writeNode(input logic [7:0] addr, input node_t n);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = n;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Called inside cycle T+1 (after the accepting edge); returns at the negedge of the first rsp_valid cycle.
  task automatic waitRsp(input string tag, input int t0, input int expLat, input int expId,
                         input logic [7:0] expY, input logic expErr);
    int n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput({tag, "_seen"}, rsp_valid, 1);
    if (rsp_valid) begin
      checkOutput({tag, "_lat"}, cyc - t0, expLat);
      checkOutput({tag, "_id"}, rsp_id, expId);
      checkOutput({tag, "_y"}, rsp_y, expY);
      checkOutput({tag, "_err"}, rsp_err, expErr);
    end
  endtask

  // Single requester transaction from an idle DUT with rsp_ready held high.
  task automatic applyStimulus(input string tag, input int r, input logic [31:0] f, input int expLat,
                               input logic [7:0] expY, input logic expErr);
    int t0;
    @(posedge clk); #1;
    req_feat[r*FV_W +: FV_W] = f;
    req_valid[r] = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_rdy"}, req_ready, 64'(1) << r);
    t0 = cyc;
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    waitRsp(tag, t0, expLat, r, expY, expErr);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int t0;
    int n;
    logic seen;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("reset_outs", {rsp_valid, rsp_id, rsp_y, rsp_err, busy, req_ready}, '0);
    checkOutput("reset_cfg_ready", cfg_ready, 1);

    // Root leaf: response three cycles after accept.
    writeNode(8'd0, mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'h5A));
    applyStimulus("t1", 0, 32'h0, 3, 8'h5A, 1'b0);

    // One decision on feature 1 against 0x10: strictly greater goes true.
    writeNode(8'd0, mkNode(1'b0, 2'd1, 8'h10, 8'd1, 8'd2, 8'h00));
    writeNode(8'd1, mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'hAA));
    writeNode(8'd2, mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'hBB));
    applyStimulus("t2_gt", 1, 32'h0000_1100, 5, 8'hAA, 1'b0);
    applyStimulus("t2_eq", 2, 32'h0000_1000, 5, 8'hBB, 1'b0);

    // All four requesting after reset: grants 0,1,2,3,0.
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    req_feat[0*FV_W +: FV_W] = 32'h0000_2000;
    req_feat[1*FV_W +: FV_W] = 32'h0000_0500;
    req_feat[2*FV_W +: FV_W] = 32'h0000_2000;
    req_feat[3*FV_W +: FV_W] = 32'h0000_0500;
    req_valid = 4'hF;
    for (int k = 0; k < 5; k++) begin
      n = 0;
      @(negedge clk);
      while (req_ready == '0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      checkOutput($sformatf("t3_grant%0d", k), req_ready, 64'(1) << (k % 4));
      t0 = cyc;
      waitRsp($sformatf("t3_rsp%0d", k), t0, 5, k % 4, ((k % 2) == 0) ? 8'hAA : 8'hBB, 1'b0);
    end
    req_valid = '0;

    // Self-loop decision: 16th decision aborts, response at 1 + 2*16 = 33 cycles after accept.
    writeNode(8'd0, mkNode(1'b0, 2'd0, 8'h00, 8'd0, 8'd0, 8'h77));
    applyStimulus("t4", 1, 32'h0, 2 * MAXD + 1, 8'h00, 1'b1);

    // Backpressure: fields hold, config writes dropped, no grant while the result waits.
    writeNode(8'd5, mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'h55));
    writeNode(8'd0, mkNode(1'b0, 2'd0, 8'hFF, 8'd5, 8'd5, 8'h00));
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_feat[2*FV_W +: FV_W] = 32'h0;
    req_feat[3*FV_W +: FV_W] = 32'h0;
    req_valid = 4'b1100;
    @(negedge clk);
    checkOutput("t5_rdy", req_ready, 4'b0100);
    t0 = cyc;
    @(posedge clk); #1 req_valid[2] = 1'b0;
    waitRsp("t5a", t0, 5, 2, 8'h55, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      cfg_we = 1'b1; cfg_addr = 8'd5; cfg_wdata = mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'h77);
      @(negedge clk);
      checkOutput($sformatf("t5_hold%0d", k),
                  {rsp_valid, rsp_id, rsp_y, rsp_err, cfg_ready, busy, req_ready},
                  {1'b1, 2'd2, 8'h55, 1'b0, 1'b0, 1'b1, 4'b0000});
    end
    @(posedge clk); #1;
    cfg_we = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_xfer", {rsp_valid, req_ready}, {1'b1, 4'b0000});
    @(negedge clk);
    checkOutput("t5_idle", {cfg_ready, busy, rsp_valid, req_ready}, {1'b1, 1'b0, 1'b0, 4'b1000});
    t0 = cyc;
    @(posedge clk); #1 req_valid[3] = 1'b0;
    waitRsp("t5b", t0, 5, 3, 8'h55, 1'b0);

    // Reset during EVAL drops the walk; no response follows.
    writeNode(8'd0, mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'h5A));
    @(posedge clk); #1;
    req_feat[0*FV_W +: FV_W] = 32'h0;
    req_valid[0] = 1'b1;
    @(negedge clk);
    checkOutput("t6_rdy", req_ready, 4'b0001);
    @(posedge clk); #1 req_valid[0] = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) seen = 1'b1;
    end
    checkOutput("t6_norsp", seen, 0);
    checkOutput("t6_idle", {busy, cfg_ready}, 2'b01);

    // Config write and request in the same idle cycle: write wins, grant follows.
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = 8'd0; cfg_wdata = mkNode(1'b1, 2'd0, 8'h00, 8'd0, 8'd0, 8'hC3);
    req_feat[1*FV_W +: FV_W] = 32'h0;
    req_valid[1] = 1'b1;
    @(negedge clk);
    checkOutput("t6_nogrant", req_ready, 4'b0000);
    @(posedge clk); #1 cfg_we = 1'b0;
    @(negedge clk);
    checkOutput("t6_grant", req_ready, 4'b0010);
    t0 = cyc;
    @(posedge clk); #1 req_valid[1] = 1'b0;
    waitRsp("t6b", t0, 3, 1, 8'hC3, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
